// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed seven-segment driver for a common-anode
// display. Per-digit number/dash/blank modes, optional leading-zero blanking,
// optional hex glyphs. Inputs are captured into shadow registers once per
// frame, so a value that changes mid-scan never produces a torn display.
module ssd_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit HEX_EN      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [2*DIGITS-1:0]   mode,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lzb,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Segment patterns, {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Per-digit display modes; 2'b11 behaves as blank as well.
    typedef enum logic [1:0] {
        MODE_NUM   = 2'b00,
        MODE_DASH  = 2'b01,
        MODE_BLANK = 2'b10
    } digit_mode_e;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                load_pend;

    logic [4*DIGITS-1:0] sh_value;
    logic [2*DIGITS-1:0] sh_mode;
    logic [DIGITS-1:0]   sh_dp;
    logic                sh_lzb;

    logic                cnt_wrap;
    logic                load_now;

    logic [3:0]          nib_arr  [DIGITS];
    logic [1:0]          mode_arr [DIGITS];
    logic [DIGITS-1:0]   lz_blank;
    logic                above_ok;
    logic                num_zero;

    logic [3:0]          cur_nib;
    logic [1:0]          cur_mode;
    logic [6:0]          num_glyph;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;
    logic                dp_next;

    // Unpack shadow vectors into per-digit fields for indexed selection.
    for (genvar g = 0; g < DIGITS; g++) begin : g_unpack
        assign nib_arr[g]  = sh_value[4*g +: 4];
        assign mode_arr[g] = sh_mode[2*g +: 2];
    end

    assign cnt_wrap = (cnt == CNT_LAST);
    // Shadow load on the first edge after reset, then once per frame boundary.
    assign load_now = load_pend || (cnt_wrap && (idx == IDX_LAST));

    // Leading-zero blanking: walk from the top digit down; blanking continues
    // only through number-mode zeros and blank-mode digits.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch
        // or loop, so no path can leave it unassigned and infer a latch.
        lz_blank = '0;
        above_ok = 1'b1;
        num_zero = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            num_zero    = (mode_arr[i] == MODE_NUM) && (nib_arr[i] == 4'h0);
            lz_blank[i] = sh_lzb && above_ok && num_zero;
            above_ok    = above_ok && (num_zero || mode_arr[i][1]);
        end
    end

    // Numeric glyph for the nibble of the digit currently selected.
    always_comb begin
        cur_nib  = nib_arr[idx];
        cur_mode = mode_arr[idx];
        case (cur_nib)
            4'h0:    num_glyph = 7'b1000000;
            4'h1:    num_glyph = 7'b1111001;
            4'h2:    num_glyph = 7'b0100100;
            4'h3:    num_glyph = 7'b0110000;
            4'h4:    num_glyph = 7'b0011001;
            4'h5:    num_glyph = 7'b0010010;
            4'h6:    num_glyph = 7'b0000010;
            4'h7:    num_glyph = 7'b1111000;
            4'h8:    num_glyph = 7'b0000000;
            4'h9:    num_glyph = 7'b0010000;
            4'hA:    num_glyph = HEX_EN ? 7'b0001000 : SEG_BLANK;
            4'hB:    num_glyph = HEX_EN ? 7'b0000011 : SEG_BLANK;
            4'hC:    num_glyph = HEX_EN ? 7'b1000110 : SEG_BLANK;
            4'hD:    num_glyph = HEX_EN ? 7'b0100001 : SEG_BLANK;
            4'hE:    num_glyph = HEX_EN ? 7'b0000110 : SEG_BLANK;
            default: num_glyph = HEX_EN ? 7'b0001110 : SEG_BLANK;
        endcase
    end

    // Final segment/anode/dp values for the current digit, applied at the edge.
    always_comb begin
        seg_next = num_glyph;
        if (cur_mode == MODE_DASH) begin
            seg_next = SEG_DASH;
        end else if (cur_mode[1] || lz_blank[idx]) begin
            seg_next = SEG_BLANK;
        end
        an_next = ~(DIGITS'(1) << idx);
        dp_next = ~sh_dp[idx];
    end

    // Scan counters, shadow capture and registered pin outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            load_pend  <= 1'b1;
            sh_value   <= '0;
            sh_mode    <= '1;
            sh_dp      <= '0;
            sh_lzb     <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= load_now;
            if (load_now) begin
                sh_value <= value;
                sh_mode  <= mode;
                sh_dp    <= dp_in;
                sh_lzb   <= lzb;
            end
            if (load_pend) begin
                // Start-up edge: only the shadow load happens; the scan and
                // the pins start on the following edge with fresh data.
                load_pend <= 1'b0;
            end else begin
                an  <= an_next;
                seg <= seg_next;
                dp  <= dp_next;
                if (cnt_wrap) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised, time-multiplexed seven-segment display driver for a DIGITS-wide common-anode display. Each digit has its own display mode: number, dash or blank. Leading-zero blanking is optional, and hexadecimal glyphs are enabled by a parameter. Inputs are snapshotted once per scan frame so the display never tears. The block sits between the datapath (counters, registers) and the board's anode, segment and decimal-point pins.

## Interface
- DIGITS, 4: number of digits scanned; minimum 2.
- REFRESH_DIV, 100000: clock cycles each digit stays lit; minimum 2.
- HEX_EN, 0: 1 = nibbles A–F show hex glyphs; 0 = they show blank.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  4*DIGITS  digit nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost.
- mode  input  2*DIGITS  per-digit mode, mode[2i+1:2i]: 00 number, 01 dash, 10/11 blank.
- dp_in  input  DIGITS  decimal point request per digit, active-high.
- lzb  input  1  leading-zero blanking enable.
- an  output  DIGITS  anode enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse, asserted in the cycle in which the shadow registers load.

## Operation
- Refresh counter cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, digit index idx advances 0→1→…→DIGITS-1→0.
- Shadow registers hold copies of value, mode, dp_in and lzb. They load on either of these edges:
  - the edge where cnt==REFRESH_DIV-1 and idx==DIGITS-1 (frame boundary);
  - the first edge after rst deasserts, using a load_pend flag that reset sets.
- Between loads, input changes have no effect on the display.
- frame_tick is high for exactly the cycle following each load edge.
- Glyph for the current digit, computed from the shadow registers:
  - number mode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - nibbles A–F with HEX_EN=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - nibbles A–F with HEX_EN=0: 1111111.
  - dash mode: 0111111.
  - blank mode: 1111111.
- Leading-zero blanking, with shadow lzb=1: digit i (i≥1) shows 1111111 when digit i is number-mode 0 and every digit above it is either number-mode 0 or blank mode. A dash-mode digit above stops the blanking. Digit 0 is never blanked by this rule.
- dp = ~shadow dp_in[idx] in all modes, including blank.
- an = ~(1<<idx). Exactly one bit is low at any time after start-up.

## Timing
- Reset values, asserted on the first edge with rst=1 and held while rst=1:
  - cnt=0, idx=0, load_pend=1, shadow registers cleared (mode=blank).
  - an=all 1s, seg=1111111, dp=1, frame_tick=0.
- an, seg and dp are registered. Each is a function of idx and the shadow registers as they stood before the edge, so outputs lag an idx change by one cycle.
- After rst deasserts:
  - edge 1: shadow registers load and frame_tick rises;
  - edge 2: an/seg/dp show digit 0 of the loaded data.
- Each digit is lit for exactly REFRESH_DIV cycles. A full frame is DIGITS*REFRESH_DIV cycles.
- A frame-boundary load and the idx wrap to 0 happen on the same edge. Digit 0 of the new frame uses the new shadow data.
- Reset asserted mid-frame: on the next edge, outputs return to reset values. Restart follows the post-reset sequence; no partial frame is completed.
- Holding rst high for any number of cycles leaves all outputs constant.

## Test plan
- Reset: DIGITS=4, REFRESH_DIV=4, rst held 3 cycles -> an=1111, seg=1111111, dp=1, frame_tick=0. After release: frame_tick=1 one cycle later, then an=1110.
- Scan: value=16'h1234, mode=0, dp_in=4'b0100, lzb=0 -> sequence over 4-cycle intervals:
  - an=1110, seg=0011001 (4), dp=1;
  - an=1101, seg=0110000 (3), dp=1;
  - an=1011, seg=0100100 (2), dp=0;
  - an=0111, seg=1111001 (1), dp=1.
- Snapshot: change value to 16'h5678 while idx=1 -> digits 1–3 keep showing 3, 2, 1. frame_tick pulses once at the boundary, then digit 0 shows 8 (0000000).
- Leading-zero blanking: value=16'h0070, lzb=1 -> digits 3 and 2 show 1111111, digit 1 shows 1111000, digit 0 shows 1000000. Repeat with lzb=0 -> digits 3 and 2 show 1000000.
- Modes and hex: mode digit 2=01 -> 0111111; mode digit 3=10 -> 1111111. Nibble A on digit 0 -> 1111111 with HEX_EN=0, 0001000 with HEX_EN=1.
- Mid-frame reset: assert rst while idx=2 -> next edge gives an=1111 and seg=1111111. After release, scanning restarts at digit 0 after the 2-edge start-up.
